fp_adder: RTL and testbench
===========================

// Module: fp_adder
// PURPOSE
//  Multi-cycle IEEE-754 floating-point adder for the custom FPU datapath.
//  Adds two binary32 operands (or two bfloat16 operands when the BF16 option is built in).
//  Work starts on a start request; the result is presented on Product and held until the next operation completes.
//  Sequential FSM core shared by the FPU add/sub path; subtraction = flip B sign upstream.
// PARAMETERS
//  LATENCY  6  cycles from start-sampling edge to Product update (fixed, not tunable below 6)
// PORTS
//  Clock    in   1   rising-edge clock
//  reset    in   1   asynchronous, active-low reset
//  start    in   1   operation request; sampled only in IDLE
//  mode     in   1   0 = binary32, 1 = bfloat16 (only with FP_ADDER_BF16_EN)
//  A        in   32  operand A (bf16: A[15:0])
//  B        in   32  operand B (bf16: B[15:0])
//  Product  out  32  registered sum (bf16: {16'h0, sum16})
// BEHAVIOUR
//  - Reset (reset=0, async): FSM->IDLE, Product=32'h0, all internal regs cleared; ongoing op discarded.
//  - FSM: IDLE->UNPACK->ALIGN->ADD->NORM->ROUND->IDLE, one state per cycle.
//  - IDLE: on posedge with start=1, latch A,B,mode; go UNPACK. start ignored in all other states.
//  - start held high across completion re-launches with current A,B (result identical if unchanged).
//  - Product written at ROUND->IDLE edge, LATENCY=6 edges after sampling; stable otherwise.
//  - UNPACK: hidden bit 1 for exp!=0; exp==0 operands (zero/subnormal) treated as signed zero.
//  - ALIGN: swap so |X|>=|Y|; shift Y mantissa right by expX-expY into 27-bit field
//    (24 mant + guard,round,sticky); shifts >=26 leave only sticky.
//  - ADD: same signs add, different signs subtract (X-Y); result sign = sign of X.
//  - NORM: carry-out -> shift right 1, exp+1; else leading-zero count, shift left, exp-lzc.
//  - ROUND: round-to-nearest-even on G/R/S; mantissa overflow after round -> exp+1.
//  - Exact cancellation -> +0 (32'h00000000). Both operands zero -> sign = A.sign & B.sign.
//  - Overflow (biased exp >=255) -> signed infinity. Underflow (exp <=0) -> signed zero (flush).
//  - Specials: any NaN or (+inf)+(-inf) -> 32'h7FC00000; inf + finite -> that inf.
//  - Exponent arithmetic 10-bit signed internally to detect over/underflow without wrap.
// CONFIGURATION
//  FP_ADDER_BF16_EN defined: mode=1 selects bfloat16 (8-bit exp, 7-bit frac) on [15:0],
//    same datapath with 8-bit mantissa precision, same rounding/special rules,
//    NaN = 16'h7FC0, Product[31:16]=0. Latency unchanged.
//  Not defined: mode ignored, all operations binary32; no bf16 logic synthesized.
// TESTING
//  - 3F800000 + 3F800000, mode=0 -> Product=40000000 exactly 6 edges after start sampled.
//  - 3FC00000 + BFC00000 -> 00000000; 40400000 + BF800000 (3-1) -> 40000000.
//  - 3F800000 + 33800000 (1 + 2^-24, tie) -> 3F800000; 3F800001 + 33800000 -> 3F800002.
//  - 7F7FFFFF + 7F7FFFFF -> 7F800000; 7F800000 + FF800000 -> 7FC00000; 00000001 + 00000000 -> 00000000.
//  - Random signed operands, exp 124..130: Product within 0.5 ulp of real-valued A+B, RNE exact.
//  - Assert reset=0 in ALIGN -> Product=0 immediately, no later update; BF16_EN: 3F80+3F80 -> 00004000.

Source files
------------

// File: rtl/fp_adder.sv
// fp_adder: multi-cycle IEEE-754 binary32 adder (IDLE/UNPACK/ALIGN/ADD/NORM/ROUND).
// Optional bfloat16 support on the low half of the operands when FP_ADDER_BF16_EN is defined.
// Round-to-nearest-even, subnormals flushed to zero, fixed start-to-Product latency.
module fp_adder #(
  parameter int LATENCY = 6
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Product
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  localparam logic [7:0] LP_LAT = 8'(LATENCY);

  // Leading-zero count of the 27-bit working mantissa (27 when the value is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  state_t             r_state, w_next;
  logic        [7:0]  r_cnt;
  logic               w_done;
  logic        [31:0] r_a, r_b;
  logic               r_sa, r_sb, r_sx, r_sub, r_szero, r_zero, r_special;
  logic        [7:0]  r_ea, r_eb;
  logic        [23:0] r_ma, r_mb;
  logic        [31:0] r_spec_val;
  logic        [26:0] r_fx, r_fy, r_n;
  logic        [27:0] r_sum;
  logic signed [9:0]  r_e;
  logic               w_bf16;
  logic        [31:0] w_a_in, w_b_in;

`ifdef FP_ADDER_BF16_EN
  logic r_mode;
  assign w_bf16 = r_mode;
  assign w_a_in = mode ? {A[15:0], 16'h0000} : A;
  assign w_b_in = mode ? {B[15:0], 16'h0000} : B;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_bf16 = 1'b0;
  assign w_a_in = A;
  assign w_b_in = B;
`endif

  // Unpack: hidden bit, zero/subnormal flush and special-operand classification.
  logic [7:0]  w_ea, w_eb;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  assign w_ea    = r_a[30:23];
  assign w_eb    = r_b[30:23];
  assign w_nan_a = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_nan_b = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_inf_a = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_inf_b = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);

  // Align: order operands by magnitude and shift the smaller one into a 27-bit G/R/S field.
  logic        w_a_ge_b, w_sx;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [23:0] w_mx, w_my;
  logic [53:0] w_sh;
  logic [26:0] w_fy;
  assign w_a_ge_b = {r_ea, r_ma[22:0]} >= {r_eb, r_mb[22:0]};
  assign w_sx     = w_a_ge_b ? r_sa : r_sb;
  assign w_ex     = w_a_ge_b ? r_ea : r_eb;
  assign w_ey     = w_a_ge_b ? r_eb : r_ea;
  assign w_mx     = w_a_ge_b ? r_ma : r_mb;
  assign w_my     = w_a_ge_b ? r_mb : r_ma;
  assign w_d      = w_ex - w_ey;
  assign w_sh     = {w_my, 30'd0} >> w_d;
  assign w_fy     = (w_d >= 8'd27) ? {26'd0, |w_my}
                                   : {w_sh[53:28], w_sh[27] | (|w_sh[26:0])};

  // Normalize helper: leading zeros of the non-carry sum.
  logic [4:0] w_lzc;
  assign w_lzc = lzc27(r_sum[26:0]);

  // Round to nearest even at the binary32 or bfloat16 precision, then pack with over/underflow.
  logic               w_up;
  logic        [24:0] w_m25;
  logic        [22:0] w_frac;
  logic signed [9:0]  w_ef;
  logic        [31:0] w_res;
`ifdef FP_ADDER_BF16_EN
  logic       w_up8;
  logic [8:0] w_m9;
`endif
  always_comb begin
    w_up   = r_n[2] & (r_n[1] | r_n[0] | r_n[3]);
    w_m25  = {1'b0, r_n[26:3]} + {24'd0, w_up};
    w_frac = w_m25[24] ? w_m25[23:1] : w_m25[22:0];
    w_ef   = r_e + (w_m25[24] ? 10'sd1 : 10'sd0);
`ifdef FP_ADDER_BF16_EN
    w_up8  = r_n[18] & (r_n[17] | (|r_n[16:0]) | r_n[19]);
    w_m9   = {1'b0, r_n[26:19]} + {8'd0, w_up8};
    if (w_bf16) begin
      w_frac = {(w_m9[8] ? w_m9[7:1] : w_m9[6:0]), 16'h0000};
      w_ef   = r_e + (w_m9[8] ? 10'sd1 : 10'sd0);
    end else begin
      w_frac = w_frac;
      w_ef   = w_ef;
    end
`endif
    if (r_special) begin
      w_res = r_spec_val;
    end else if (r_zero) begin
      w_res = {r_szero, 31'd0};
    end else if (w_ef >= 10'sd255) begin
      w_res = {r_sx, 8'hFF, 23'd0};
    end else if (w_ef <= 10'sd0) begin
      w_res = {r_sx, 31'd0};
    end else begin
      w_res = {r_sx, w_ef[7:0], w_frac};
    end
  end

  assign w_done = (r_cnt >= LP_LAT);

  // FSM state register.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state: one state per cycle, ROUND held until the fixed latency has elapsed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_UNPACK : S_IDLE;
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ADD;
      S_ADD:    w_next = S_NORM;
      S_NORM:   w_next = S_ROUND;
      S_ROUND:  w_next = w_done ? S_IDLE : S_ROUND;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath registers: each stage writes its results when the FSM is in that stage.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= 8'd0; r_a <= 32'd0; r_b <= 32'd0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_sx <= 1'b0; r_sub <= 1'b0;
      r_szero <= 1'b0; r_zero <= 1'b0; r_special <= 1'b0;
      r_ea <= 8'd0; r_eb <= 8'd0; r_ma <= 24'd0; r_mb <= 24'd0;
      r_spec_val <= 32'd0; r_fx <= 27'd0; r_fy <= 27'd0; r_n <= 27'd0;
      r_sum <= 28'd0; r_e <= 10'sd0; Product <= 32'd0;
`ifdef FP_ADDER_BF16_EN
      r_mode <= 1'b0;
`endif
    end else begin
      r_cnt <= (r_state == S_IDLE) ? 8'd1 : r_cnt + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= w_a_in;
            r_b <= w_b_in;
`ifdef FP_ADDER_BF16_EN
            r_mode <= mode;
`endif
          end
        end
        S_UNPACK: begin
          r_sa    <= r_a[31];
          r_sb    <= r_b[31];
          r_szero <= r_a[31] & r_b[31];
          r_ea    <= w_ea;
          r_eb    <= w_eb;
          r_ma    <= (w_ea != 8'd0) ? {1'b1, r_a[22:0]} : 24'd0;
          r_mb    <= (w_eb != 8'd0) ? {1'b1, r_b[22:0]} : 24'd0;
          r_special <= w_nan_a | w_nan_b | w_inf_a | w_inf_b;
          if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (r_a[31] != r_b[31])))
            r_spec_val <= 32'h7FC00000;
          else if (w_inf_a)
            r_spec_val <= {r_a[31], 8'hFF, 23'd0};
          else
            r_spec_val <= {r_b[31], 8'hFF, 23'd0};
        end
        S_ALIGN: begin
          r_sx  <= w_sx;
          r_sub <= r_sa ^ r_sb;
          r_fx  <= {w_mx, 3'b000};
          r_fy  <= w_fy;
          r_e   <= $signed({2'b00, w_ex});
        end
        S_ADD: begin
          r_sum <= r_sub ? ({1'b0, r_fx} - {1'b0, r_fy}) : ({1'b0, r_fx} + {1'b0, r_fy});
        end
        S_NORM: begin
          r_zero <= (r_sum == 28'd0);
          if (r_sum[27]) begin
            r_n <= {r_sum[27:2], r_sum[1] | r_sum[0]};
            r_e <= r_e + 10'sd1;
          end else begin
            r_n <= r_sum[26:0] << w_lzc;
            r_e <= r_e - $signed({5'd0, w_lzc});
          end
        end
        S_ROUND: begin
          if (w_done) Product <= w_bf16 ? {16'h0000, w_res[31:16]} : w_res;
          else        Product <= Product;
        end
        default: begin
          r_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// Directed self-checking bench for fp_adder: latency, rounding, specials, relaunch, mid-op reset.
module tb_fp_adder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Product;

  int          n_chk;
  int          n_fail;
  logic [31:0] prev;

  fp_adder dut (
    .Clock   (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .A       (A),
    .B       (B),
    .Product (Product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One operation: Product must hold the old value after 5 edges and show the new one after 6.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic m, input logic [31:0] expv);
    @(negedge clk);
    A = a; B = b; mode = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1 chk({tag, "_hold"}, Product, prev);
    @(posedge clk);
    #1 chk(tag, Product, expv);
    prev = expv;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; prev = 32'h0;
    reset = 1'b0; start = 1'b0; mode = 1'b0; A = 32'h0; B = 32'h0;
    #22 chk("reset", Product, 32'h0);
    @(negedge clk) reset = 1'b1;

    do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    do_op("cancel",       32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000);
    do_op("three_m_one",  32'h40400000, 32'hBF800000, 1'b0, 32'h40000000);
    do_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    do_op("tie_odd",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
    do_op("above_tie",    32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001);
    do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    do_op("inf_m_inf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
    do_op("subnorm",      32'h00000001, 32'h00000000, 1'b0, 32'h00000000);
    do_op("two_p_one",    32'h40000000, 32'h3F800000, 1'b0, 32'h40400000);
    do_op("one_m_half",   32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000);
    do_op("ninf_p_fin",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000);
    do_op("nan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000);
    do_op("neg_sum",      32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000);
    do_op("nz_p_nz",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    do_op("nz_p_pz",      32'h80000000, 32'h00000000, 1'b0, 32'h00000000);
    do_op("underflow",    32'h00800000, 32'h80800001, 1'b0, 32'h80000000);
`ifdef FP_ADDER_BF16_EN
    do_op("bf16_add",     32'hDEAD3F80, 32'hBEEF3F80, 1'b1, 32'h00004000);
    do_op("bf16_tie",     32'h00003F80, 32'h00003B80, 1'b1, 32'h00003F80);
    do_op("bf16_cancel",  32'h00003F80, 32'h0000BF80, 1'b1, 32'h00000000);
`else
    do_op("mode_ignored", 32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000);
`endif

    // start held high across completion relaunches with the operands present at that time
    @(negedge clk);
    A = 32'h3F800000; B = 32'h3F800000; mode = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 chk("relaunch_first", Product, 32'h40000000);
    @(negedge clk);
    A = 32'h40000000; B = 32'h40000000;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("relaunch_hold", Product, 32'h40000000);
    @(posedge clk);
    #1 chk("relaunch_second", Product, 32'h40800000);
    start = 1'b0;
    prev = 32'h40800000;

    // reset asserted while the operation is in ALIGN clears Product and discards the op
    @(negedge clk);
    A = 32'h3F800000; B = 32'h3F800000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("rst_align", Product, 32'h0);
    @(negedge clk) reset = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("rst_no_update", Product, 32'h0);
    prev = 32'h0;

    do_op("after_reset", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
